// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and load-length cap.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    FLUSH  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6
  } state_t;

  function automatic int unsigned max_len_for(input int unsigned depth_words);
    return 4 * depth_words;
  endfunction

  localparam int unsigned MAX_LEN = max_len_for(512);

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian bytes into 32-bit words; pulses word_stb one cycle after a
// word completes, or combinationally while flush writes out the zero-padded partial word.
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  byte_in,
  input  logic        flush,
  output logic [31:0] word,
  output logic        word_stb,
  output logic [1:0]  lane
);

  logic [1:0]  lane_q;
  logic [31:0] part_q;
  logic [31:0] full_q;
  logic        full_stb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q     <= 2'd0;
      part_q     <= 32'd0;
      full_q     <= 32'd0;
      full_stb_q <= 1'b0;
    end else begin
      full_stb_q <= 1'b0;
      if (clear || flush) begin
        lane_q <= 2'd0;
        part_q <= 32'd0;
      end else if (push) begin
        // The partial register is cleared on completion so a later flush pads with zeros.
        if (lane_q == 2'd3) begin
          full_q     <= {byte_in, part_q[23:0]};
          full_stb_q <= 1'b1;
          part_q     <= 32'd0;
        end else begin
          part_q[8*lane_q +: 8] <= byte_in;
        end
        lane_q <= lane_q + 2'd1;
      end
    end
  end

  assign word     = flush ? part_q : full_q;
  assign word_stb = full_stb_q | flush;
  assign lane     = lane_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into program RAM as packed 32-bit words.
// Define LOADER_CHECKSUM_EN to require a trailing checksum byte after the payload.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DEPTH_WORDS = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data_out,
  output logic                  mem_write_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_dbg
);

  localparam int          IDX_W   = ADDR_WIDTH - 2;
  localparam logic [15:0] LEN_CAP = 16'(max_len_for(DEPTH_WORDS));
`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = CHECK;
`else
  localparam state_t AFTER_PAYLOAD = DONE;
`endif

  state_t           state_q, state_d;
  logic [7:0]       len_lo_q;
  logic [15:0]      rem_q;
  logic [15:0]      len_full;
  logic [IDX_W-1:0] idx_q;
  logic             done_q, error_q, set_err;
  logic             pk_clear, pk_push, pk_flush, pk_stb;
  logic [31:0]      pk_word;
  logic [1:0]       pk_lane;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]       sum_q;
`endif

  assign len_full = {byte_in, len_lo_q};

  word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (pk_clear),
    .push     (pk_push),
    .byte_in  (byte_in),
    .flush    (pk_flush),
    .word     (pk_word),
    .word_stb (pk_stb),
    .lane     (pk_lane)
  );

  // Handshake: a byte transfers on a clk edge where byte_valid && byte_ready; byte_ready
  // depends only on state, and byte_valid while byte_ready=0 has no effect.
  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    pk_clear   = 1'b0;
    pk_push    = 1'b0;
    pk_flush   = 1'b0;
    set_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LEN_LO;
          pk_clear = 1'b1;
        end
      end
      LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) state_d = LEN_HI;
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          if (len_full == 16'd0) begin
            state_d = AFTER_PAYLOAD;
          end else if (len_full > LEN_CAP) begin
            state_d = DONE;
            set_err = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          pk_push = 1'b1;
          // Lane 3 means this byte completes a word, so nothing is left to flush.
          if (rem_q == 16'd1) state_d = (pk_lane != 2'd3) ? FLUSH : AFTER_PAYLOAD;
        end
      end
      FLUSH: begin
        pk_flush = 1'b1;
        state_d  = AFTER_PAYLOAD;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_d = DONE;
          if (8'(sum_q + byte_in) != 8'd0) set_err = 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      len_lo_q <= 8'd0;
      rem_q    <= 16'd0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q    <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == LEN_LO && byte_valid) len_lo_q <= byte_in;
      if (state_q == LEN_HI && byte_valid) rem_q <= len_full;
      if (pk_push) begin
        rem_q <= rem_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
        sum_q <= sum_q + byte_in;
`endif
      end
      if (pk_stb) idx_q <= idx_q + 1'b1;
      if (state_q == IDLE && start) begin
        done_q  <= 1'b0;
        error_q <= 1'b0;
        idx_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum_q   <= 8'd0;
`endif
      end
      if (state_d == DONE && state_q != DONE) done_q <= 1'b1;
      if (set_err) error_q <= 1'b1;
    end
  end

  assign mem_address      = {idx_q, 2'b00};
  assign mem_data_out     = pk_word;
  assign mem_write_enable = pk_stb;
  assign busy             = (state_q != IDLE) && (state_q != DONE);
  assign done             = done_q;
  assign error            = error_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: random and directed loads checked against a stream-level model.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [11:0] mem_address;
  logic [31:0] mem_data_out;
  logic        mem_write_enable;
  logic        busy, done, error;
  logic [2:0]  state_dbg;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [43:0] exp_q[$];
  int          obs_cyc_q[$];
  int          xfer_cyc_q[$];
  logic [7:0]  stream_q[$];
  logic        exp_err;
  int          exp_len;
  int          exp_words;

  program_loader #(.ADDR_WIDTH(12), .DEPTH_WORDS(512)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .byte_in          (byte_in),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .mem_address      (mem_address),
    .mem_data_out     (mem_data_out),
    .mem_write_enable (mem_write_enable),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .state_dbg        (state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // write monitor: every strobe must match the next expected word
  always @(negedge clk) begin
    if (mem_write_enable === 1'b1) begin
      logic [43:0] e;
      obs_cyc_q.push_back(cyc);
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_address), 64'(e[43:32]));
        check("wr_data", 64'(mem_data_out), 64'(e[31:0]));
      end
    end
  end

  // reference model: expected words and error flag from the stream contents alone
  task automatic model_build();
    logic [31:0] w;
    exp_q.delete();
    exp_len   = int'({stream_q[1], stream_q[0]});
    exp_err   = 1'b0;
    exp_words = 0;
    if (exp_len > 2048) begin
      exp_err = 1'b1;
      return;
    end
    exp_words = (exp_len + 3) / 4;
    for (int wi = 0; wi < exp_words; wi++) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++)
        if (4*wi + j < exp_len) w = w | (32'(stream_q[2 + 4*wi + j]) << (8*j));
      exp_q.push_back({12'(4*wi), w});
    end
`ifdef LOADER_CHECKSUM_EN
    begin
      int s;
      s = 0;
      for (int k = 0; k < exp_len; k++) s += int'(stream_q[2 + k]);
      s += int'(stream_q[2 + exp_len]);
      exp_err = ((s % 256) != 0);
    end
`endif
  endtask

  task automatic append_ck(input bit good);
    int s;
    logic [7:0] ck;
    s = 0;
    for (int k = 2; k < stream_q.size(); k++) s += int'(stream_q[k]);
    ck = 8'((256 - (s % 256)) % 256);
    if (!good) ck = ck + 8'($urandom_range(1, 255));
    stream_q.push_back(ck);
  endtask

  task automatic make_stream(input int len, input bit good);
    stream_q.delete();
    stream_q.push_back(8'(len));
    stream_q.push_back(8'(len >> 8));
    if (len <= 2048) begin
      for (int k = 0; k < len; k++) stream_q.push_back(8'($urandom));
`ifdef LOADER_CHECKSUM_EN
      append_ck(good);
`else
      if (good) stream_q = stream_q;
`endif
    end
  endtask

  // driver tasks
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", 64'(byte_ready), 64'd1);
    @(negedge clk);
    xfer_cyc_q.push_back(cyc);
    byte_valid = 1'b0;
  endtask

  task automatic gap(input int k, input bit with_start);
    for (int i = 0; i < k; i++) begin
      byte_valid = 1'b0;
      byte_in    = 8'($urandom);
      start      = with_start && (i == 0);
      @(negedge clk);
      start      = 1'b0;
    end
  endtask

  task automatic run_load(input int gap_pct, input bit noisy);
    int n;
    int last;
    model_build();
    obs_cyc_q.delete();
    xfer_cyc_q.delete();
    if (noisy) begin
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      repeat (2) @(negedge clk);
      byte_valid = 1'b0;
    end
    pulse_start();
    check("busy_start", 64'(busy), 64'd1);
    check("done_clr", 64'(done), 64'd0);
    check("err_clr", 64'(error), 64'd0);
    for (int i = 0; i < stream_q.size(); i++) begin
      if ($urandom_range(0, 99) < gap_pct) gap($urandom_range(1, 3), noisy);
      send_byte(stream_q[i]);
    end
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("done", 64'(done), 64'd1);
    repeat (2) @(negedge clk);
    check("error", 64'(error), 64'(exp_err));
    check("busy_end", 64'(busy), 64'd0);
    check("done_held", 64'(done), 64'd1);
    check("wr_count", 64'(obs_cyc_q.size()), 64'(exp_words));
    check("wr_left", 64'(exp_q.size()), 64'd0);
    for (int w = 0; w < exp_words && w < obs_cyc_q.size(); w++) begin
      last = (4*w + 3 < exp_len) ? 4*w + 3 : exp_len - 1;
      check("wr_cycle", 64'(obs_cyc_q[w]), 64'(xfer_cyc_q[2 + last]));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(byte_ready), 64'd0);
    check({tag, "_addr"}, 64'(mem_address), 64'd0);
    check({tag, "_data"}, 64'(mem_data_out), 64'd0);
    check({tag, "_we"}, 64'(mem_write_enable), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(error), 64'd0);
  endtask

  initial begin
    int len;
    // reset block
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;
    @(negedge clk);

    // two full words at full rate
    stream_q = '{8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef LOADER_CHECKSUM_EN
    append_ck(1'b1);
`endif
    run_load(0, 1'b0);

    // partial final word flushed with zero padding
    stream_q = '{8'h05, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
`ifdef LOADER_CHECKSUM_EN
    append_ck(1'b1);
`endif
    run_load(0, 1'b0);

    // oversized length, then zero length
    stream_q = '{8'h01, 8'h08};
    run_load(0, 1'b0);
    stream_q = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    append_ck(1'b1);
`endif
    run_load(0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    stream_q = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
    run_load(0, 1'b0);
    stream_q = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
    run_load(0, 1'b0);
`endif

    // reset between bytes 2 and 3 of a word aborts with no write
    exp_q.delete();
    obs_cyc_q.delete();
    pulse_start();
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_wr", 64'(obs_cyc_q.size()), 64'd0);

    // same load again with gaps, stray valids and a start pulse while busy
    stream_q = '{8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
`ifdef LOADER_CHECKSUM_EN
    append_ck(1'b1);
`endif
    run_load(40, 1'b1);

    // largest legal load
    make_stream(2048, 1'b1);
    run_load(0, 1'b0);

    // randomized loads
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(2049, 65535);
      else len = $urandom_range(0, 23);
      make_stream(len, $urandom_range(0, 3) != 0);
      run_load((r % 2) ? 30 : 0, (r % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    check("global_timeout", 64'(cyc), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
